// File: rtl/wave_synth_pkg.sv
// Shared types and reset defaults for the wave synthesis core.
// Config fields applied together at a phase wrap travel as one packed struct.
package wave_synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SIN = 2'd0,
        WAVE_SQR = 2'd1,
        WAVE_TRI = 2'd2,
        WAVE_SAW = 2'd3
    } wave_t;

    typedef struct packed {
        wave_t      wave;
        logic [7:0] duty;
        logic       phase_rst;
    } cfg_t;

    localparam wave_t      WAVE_RST = WAVE_SIN;
    localparam logic [7:0] DUTY_RST = 8'd128;
    localparam cfg_t       CFG_RST  = '{wave: WAVE_SIN, duty: 8'd128, phase_rst: 1'b0};

endpackage

// File: rtl/wave_quarter_lut.sv
// Quarter-wave sine ROM, magnitude only, contents built at elaboration.
// Latency 1 cycle (registered read); no backpressure, reads every cycle.
module wave_quarter_lut #(
    parameter int DATA_W = 12,
    parameter int LUT_AW = 10
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-2:0] q
);

    localparam int  DEPTH = 1 << LUT_AW;
    localparam real MAG   = real'((1 << (DATA_W - 1)) - 1);

    // Half-step offset keeps the table symmetric so ~i mirrors cleanly.
    function automatic logic [DATA_W-2:0] entry(input int idx);
        real x;
        x = MAG * $sin(3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(DEPTH));
        return (DATA_W-1)'($rtoi(x + 0.5));
    endfunction

    logic [DATA_W-2:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = entry(g);
    end

    always_ff @(posedge clk) begin
        q <= rom[addr];
    end

endmodule

// File: rtl/wave_synth_core.sv
// DDS core: phase accumulator driving sine/square/triangle/saw with gain, offset-binary out.
// Latency 3 cycles en->dout_valid, full throughput; config is single-entry, cfg_ready low
// while a config waits for the next phase wrap (or an idle en=0 cycle).
module wave_synth_core
    import wave_synth_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 10,
    parameter int AMP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_wave,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [AMP_W:0]    cfg_amp,
    input  logic [7:0]        cfg_duty,
    input  logic              cfg_phase_rst,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    localparam int PH_A = (DATA_W + 1 > LUT_AW + 2) ? DATA_W + 1 : LUT_AW + 2;
    localparam int PH_W = (PH_A > 8) ? PH_A : 8;
    localparam int PW   = DATA_W + AMP_W + 2;

    localparam logic [AMP_W:0]           AMP_ONE = {1'b1, {AMP_W{1'b0}}};
    localparam logic [DATA_W-1:0]        MID     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};

    logic [ACC_W-1:0] acc, ftw, sum, pnd_ftw;
    logic             carry, pnd_vld, apply;
    logic [AMP_W:0]   amp, pnd_amp, amp_in;
    wave_t            cur_wave;
    logic [7:0]       cur_duty;
    cfg_t             pnd_cfg;

    assign {carry, sum} = {1'b0, acc} + {1'b0, ftw};
    assign cfg_ready    = !pnd_vld;
    assign apply        = pnd_vld && (!en || carry);
    assign amp_in       = (cfg_amp > AMP_ONE) ? AMP_ONE : cfg_amp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            ftw      <= '0;
            amp      <= AMP_ONE;
            cur_wave <= WAVE_RST;
            cur_duty <= DUTY_RST;
            pnd_vld  <= 1'b0;
            pnd_ftw  <= '0;
            pnd_amp  <= AMP_ONE;
            pnd_cfg  <= CFG_RST;
        end else begin
            // The sample launched this cycle already carries the old config.
            if (apply) begin
                acc      <= pnd_cfg.phase_rst ? '0 : (en ? sum : acc);
                ftw      <= pnd_ftw;
                amp      <= pnd_amp;
                cur_wave <= pnd_cfg.wave;
                cur_duty <= pnd_cfg.duty;
                pnd_vld  <= 1'b0;
            end else if (en) begin
                acc <= sum;
            end
            if (cfg_valid && cfg_ready) begin
                pnd_vld <= 1'b1;
                pnd_ftw <= cfg_ftw;
                pnd_amp <= amp_in;
                pnd_cfg <= '{wave: wave_t'(cfg_wave), duty: cfg_duty, phase_rst: cfg_phase_rst};
            end
        end
    end

    // S1: phase capture with the config in force at launch.
    logic            s1_vld;
    logic [PH_W-1:0] s1_p;
    wave_t           s1_wave;
    logic [7:0]      s1_duty;
    logic [AMP_W:0]  s1_amp;

    always_ff @(posedge clk) begin
        if (!rst_n) s1_vld <= 1'b0;
        else        s1_vld <= en;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_p    <= acc[ACC_W-1 -: PH_W];
            s1_wave <= cur_wave;
            s1_duty <= cur_duty;
            s1_amp  <= amp;
        end
    end

    logic [LUT_AW-1:0] lut_idx, lut_addr;
    logic [DATA_W-2:0] lut_q;

    assign lut_idx  = s1_p[PH_W-3 -: LUT_AW];
    assign lut_addr = s1_p[PH_W-2] ? ~lut_idx : lut_idx;

    wave_quarter_lut #(.DATA_W(DATA_W), .LUT_AW(LUT_AW)) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .q    (lut_q)
    );

    // S2: non-sine shapes computed alongside the ROM read.
    logic [DATA_W:0]             tri_u;
    logic [DATA_W-1:0]           tri_t;
    logic signed [DATA_W-1:0]    s1_shape;

    always_comb begin
        tri_u = s1_p[PH_W-1 -: DATA_W+1];
        tri_t = tri_u[DATA_W] ? ~tri_u[DATA_W-1:0] : tri_u[DATA_W-1:0];
        case (s1_wave)
            WAVE_SQR: s1_shape = (s1_p[PH_W-1 -: 8] < s1_duty) ? S_MAX : -S_MAX;
            WAVE_TRI: s1_shape = {~tri_t[DATA_W-1], tri_t[DATA_W-2:0]};
            default:  s1_shape = {~s1_p[PH_W-1], s1_p[PH_W-2 -: DATA_W-1]};
        endcase
    end

    logic                     s2_vld, s2_sin, s2_neg;
    logic signed [DATA_W-1:0] s2_shape;
    logic [AMP_W:0]           s2_amp;

    always_ff @(posedge clk) begin
        if (!rst_n) s2_vld <= 1'b0;
        else        s2_vld <= s1_vld;
    end

    always_ff @(posedge clk) begin
        s2_sin   <= (s1_wave == WAVE_SIN);
        s2_neg   <= s1_p[PH_W-1];
        s2_shape <= s1_shape;
        s2_amp   <= s1_amp;
    end

    // S3: sign the ROM magnitude, scale, re-bias to offset binary.
    logic signed [DATA_W-1:0] lut_s, sel;
    logic signed [PW-1:0]     prod;

    assign lut_s = {1'b0, lut_q};
    assign sel   = s2_sin ? (s2_neg ? -lut_s : lut_s) : s2_shape;
    assign prod  = PW'(sel) * PW'($signed({1'b0, s2_amp}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= MID;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= s2_vld;
            if (s2_vld) dout <= MID + DATA_W'(prod >>> AMP_W);
        end
    end

endmodule

// File: tb/tb_wave_synth_core.sv
// Directed and random stimulus for wave_synth_core against a per-sample reference model.
module tb_wave_synth_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, cfg_valid = 1'b0, cfg_phase_rst = 1'b0;
    logic [1:0]  cfg_wave = '0;
    logic [31:0] cfg_ftw = '0;
    logic [8:0]  cfg_amp = '0;
    logic [7:0]  cfg_duty = '0;
    logic        cfg_ready, dout_valid;
    logic [11:0] dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wave_synth_core #(.DATA_W(12), .ACC_W(32), .LUT_AW(10), .AMP_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_wave      (cfg_wave),
        .cfg_ftw       (cfg_ftw),
        .cfg_amp       (cfg_amp),
        .cfg_duty      (cfg_duty),
        .cfg_phase_rst (cfg_phase_rst),
        .dout          (dout),
        .dout_valid    (dout_valid)
    );

    typedef struct { int wave; longint ftw; int amp; int duty; bit prst; } cfg_s;

    cfg_s   cur, pnd;
    bit     pnd_vld = 0;
    longint m_acc = 0;
    int     m_dout = 2048;
    bit     m_dv = 0;
    int     pv[3];
    bit     pvl[3];
    int     samples[$];

    function automatic int sine_lut(int i);
        real x;
        x = 2047.0 * $sin(3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / 1024.0);
        return $rtoi(x + 0.5);
    endfunction

    // Expected offset-binary sample for phase p under config c.
    function automatic int ref_sample(longint p, cfg_s c);
        int ph, s, q, i, u, t;
        ph = int'(p >> 20);
        case (c.wave)
            0: begin
                q = ph / 1024;
                i = ph % 1024;
                if (q % 2 == 1) i = 1023 - i;
                s = sine_lut(i);
                if (q >= 2) s = -s;
            end
            1: s = ((p >> 24) < longint'(c.duty)) ? 2047 : -2047;
            2: begin
                u = int'(p >> 19);
                t = (u >= 4096) ? 8191 - u : u;
                s = t - 2048;
            end
            default: s = ph - 2048;
        endcase
        return 2048 + ((s * c.amp) >>> 8);
    endfunction

    task automatic model_edge();
        longint nxt;
        bit     wrap, rdy;
        if (!rst_n) begin
            cur = '{0, 0, 256, 128, 1'b0};
            pnd_vld = 0;
            m_acc = 0;
            m_dout = 2048;
            m_dv = 0;
            for (int k = 0; k < 3; k++) pvl[k] = 0;
            return;
        end
        pv[2] = pv[1]; pvl[2] = pvl[1];
        pv[1] = pv[0]; pvl[1] = pvl[0];
        pvl[0] = en;
        pv[0] = en ? ref_sample(m_acc, cur) : 0;
        m_dv = pvl[2];
        if (pvl[2]) m_dout = pv[2];
        rdy = !pnd_vld;
        nxt = en ? m_acc + cur.ftw : m_acc;
        wrap = nxt >= (longint'(1) << 32);
        nxt = nxt & 64'hFFFF_FFFF;
        if (pnd_vld && (!en || wrap)) begin
            cur = pnd;
            if (pnd.prst) nxt = 0;
            pnd_vld = 0;
        end
        if (cfg_valid && rdy) begin
            pnd = '{int'(cfg_wave), longint'(cfg_ftw), (cfg_amp > 9'd256) ? 256 : int'(cfg_amp),
                    int'(cfg_duty), cfg_phase_rst};
            pnd_vld = 1;
        end
        m_acc = nxt;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("dout", dout, m_dout);
        chk("dout_valid", dout_valid, m_dv);
        chk("cfg_ready", cfg_ready, !pnd_vld);
        if (dout_valid === 1'b1) samples.push_back(int'(dout));
    endtask

    task automatic offer(int w, longint f, int a, int d, bit pr);
        int n;
        n = 0;
        cfg_wave = 2'(w); cfg_ftw = 32'(f); cfg_amp = 9'(a); cfg_duty = 8'(d);
        cfg_phase_rst = pr; cfg_valid = 1'b1;
        while (pnd_vld && n < 2000) begin tick(); n++; end
        total++;
        assert (n < 2000) else begin bad++; $error("FAIL offer_timeout: got %0d want <2000", n); end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_applied(int limit);
        int n;
        n = 0;
        while (pnd_vld && n < limit) begin tick(); n++; end
        total++;
        assert (n < limit) else begin bad++; $error("FAIL apply_timeout: got %0d want <%0d", n, limit); end
    endtask

    initial begin
        int j, hi, lo, mx, mn;

        repeat (3) tick();
        chk("rst_dout", dout, 2048);
        chk("rst_dv", dout_valid, 0);
        chk("rst_rdy", cfg_ready, 1);

        // Sine at ftw=0: latency and first LUT entry.
        rst_n = 1; en = 1;
        tick(); chk("lat1_dv", dout_valid, 0);
        tick(); chk("lat2_dv", dout_valid, 0);
        tick(); chk("lat3_dv", dout_valid, 1);
        chk("sin0", dout, 2050);

        // ftw=0 with en=1 never wraps: config waits for an idle cycle.
        offer(3, 64'd1 << 24, 256, 0, 0);
        repeat (5) tick();
        chk("pend_rdy", cfg_ready, 0);
        en = 0; tick();
        chk("apply_rdy", cfg_ready, 1);
        repeat (3) tick();

        samples.delete();
        en = 1; repeat (300) tick();
        en = 0; repeat (4) tick();
        chk("saw_cnt", samples.size(), 300);
        for (int k = 0; k < 300 && k < samples.size(); k++)
            chk("saw_val", samples[k], 16 * (k % 256));

        // Square queued mid-period; old wave runs through the wrap sample.
        samples.delete();
        en = 1;
        offer(1, 64'd1 << 24, 256, 64, 1);
        chk("sq_pend_rdy", cfg_ready, 0);
        repeat (600) tick();
        en = 0; repeat (4) tick();
        j = -1;
        for (int k = 0; k < samples.size(); k++)
            if (j < 0 && (samples[k] == 4095 || samples[k] == 1)) j = k;
        chk("sq_found", (j >= 1 && j + 256 <= samples.size()), 1);
        if (j >= 1 && j + 256 <= samples.size()) begin
            chk("wrap_sample_saw", samples[j-1], 4080);
            chk("sq_first", samples[j], 4095);
            chk("sq_fall", samples[j+64], 1);
            hi = 0; lo = 0;
            for (int k = j; k < j + 256; k++) begin
                if (samples[k] == 4095) hi++;
                if (samples[k] == 1) lo++;
            end
            chk("sq_hi_cnt", hi, 64);
            chk("sq_lo_cnt", lo, 192);
        end

        // Triangle at half gain.
        en = 1;
        offer(2, 64'd1 << 22, 128, 0, 1);
        wait_applied(400);
        repeat (4) tick();
        samples.delete();
        repeat (1100) tick();
        en = 0; repeat (4) tick();
        mx = 0; mn = 4096;
        foreach (samples[k]) begin
            if (samples[k] > mx) mx = samples[k];
            if (samples[k] < mn) mn = samples[k];
        end
        chk("tri_max", mx, 3071);
        chk("tri_min", mn, 1024);

        // Random traffic, including gains above unity and phase resets.
        repeat (1500) begin
            en = ($urandom_range(0, 3) != 0);
            if (!pnd_vld && $urandom_range(0, 9) == 0) begin
                cfg_wave = 2'($urandom_range(0, 3));
                cfg_ftw = $urandom() >> $urandom_range(0, 10);
                cfg_amp = 9'($urandom_range(0, 511));
                cfg_duty = 8'($urandom_range(0, 255));
                cfg_phase_rst = 1'($urandom_range(0, 1));
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
        end
        cfg_valid = 1'b0;

        // Reset mid-stream drops a pending config.
        en = 0;
        offer(0, 0, 256, 128, 0);
        tick();
        en = 1;
        offer(1, 64'd1 << 24, 256, 200, 0);
        repeat (3) tick();
        chk("pre_rst_rdy", cfg_ready, 0);
        rst_n = 0; tick();
        chk("mid_rst_dout", dout, 2048);
        chk("mid_rst_dv", dout_valid, 0);
        chk("mid_rst_rdy", cfg_ready, 1);
        rst_n = 1; en = 0; tick();
        en = 1; repeat (5) tick();
        chk("post_rst_dv", dout_valid, 1);
        chk("post_rst_dout", dout, 2050);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_synth_core.md
# wave_synth_core

Parametrised direct-digital-synthesis core producing one waveform sample per enabled clock from a phase accumulator. Successor to the fixed three-ROM, externally addressed waveform bank: it supplies its own phase and adds a sawtooth mode and a duty-cycle square. It also adds amplitude scaling and phase-continuous reconfiguration through a valid/ready config port. Its output drives the DAC/display sample path as offset-binary data.

## Interface
- DATA_W, 12, output sample width (offset binary)
- ACC_W, 32, phase accumulator width
- LUT_AW, 10, quarter-wave sine table address width
- AMP_W, 8, amplitude fraction bits; cfg_amp = 2^AMP_W is unity gain
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  advance accumulator and launch one sample this cycle
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
- cfg_wave  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
- cfg_ftw  in  ACC_W  frequency tuning word
- cfg_amp  in  AMP_W+1  gain; values above 2^AMP_W are clamped to 2^AMP_W
- cfg_duty  in  8  square high fraction, duty/256
- cfg_phase_rst  in  1  clear accumulator when this config is applied
- dout  out  DATA_W  sample, offset binary
- dout_valid  out  1  dout holds a new sample this cycle

## Operation
- Reset values: acc=0, ftw=0, wave=sine, amp=2^AMP_W, duty=128, no pending config. Outputs: dout=2^(DATA_W-1), dout_valid=0, cfg_ready=1.
- Accumulator: on en, acc <= acc + ftw (mod 2^ACC_W). The sample uses the pre-add phase p. When en=0, acc holds and no sample launches.
- Config handshake: on accept, fields latch into a pending register and cfg_ready drops.
  - Pending config applies at the first en cycle whose addition carries out of ACC_W (wrap), or on the next cycle if en=0 at that time.
  - New values take effect for the increment/sample after application; the wrap-cycle sample still uses the old config.
  - cfg_ready returns to 1 the cycle after application.
  - If cfg_phase_rst is set, acc is loaded with 0 on application instead of the wrapped sum.
  - ftw=0 with en=1 never wraps; the config stays pending until en=0.
- Waveforms, signed intermediate s, with M = 2^(DATA_W-1)-1:
  - Sine: quadrant q = p[ACC_W-1:ACC_W-2], index i = p[ACC_W-3 -: LUT_AW].
    - Quadrants 1 and 3 read the LUT at ~i; quadrants 2 and 3 negate the result.
    - LUT[i] = round(M*sin(pi/2*(i+0.5)/2^LUT_AW)).
  - Square: s = +M if p[ACC_W-1 -: 8] < duty, else -M. duty=0 gives constant -M.
  - Triangle: u = p[ACC_W-1 -: DATA_W+1]; t = u[DATA_W] ? ~u[DATA_W-1:0] : u[DATA_W-1:0]; s = t - 2^(DATA_W-1).
  - Sawtooth: s = p[ACC_W-1 -: DATA_W] with MSB inverted, read as signed.
- Scaling: dout = 2^(DATA_W-1) + ((s*amp) >>> AMP_W), arithmetic shift, full-precision product. No overflow is possible, so no saturation is needed.

## Timing
- Latency of 3 cycles from the en cycle to dout_valid. Stages:
  - S1: phase capture and LUT address.
  - S2: LUT read and non-sine compute.
  - S3: select, sign and multiply, then registered dout.
- dout_valid is a delayed copy of en. dout holds its last value when dout_valid=0.
- Full throughput: one sample per clock with en held high.
- Config application is never earlier than the cycle after acceptance. A wrap in the accept cycle itself does not apply it.
- rst_n low at any edge clears acc, pending config and the valid pipeline. In-flight samples are discarded and dout returns to midscale the next cycle.

## Structure
- Package wave_synth_pkg holds the wave-select enum (WAVE_SIN, WAVE_SQR, WAVE_TRI, WAVE_SAW), the config struct, and the reset-default constants.
- Sub-module wave_quarter_lut: synchronous-read ROM, parameters DATA_W/LUT_AW, 1-cycle latency, contents generated at elaboration.

## Test plan
- Reset, then en=1 with ftw=0 and sine → dout_valid rises 3 cycles after en; dout = 2048 + LUT[0] (≈2050) for DATA_W=12.
- Sawtooth, ftw=2^24, amp=256 → 256-sample period; dout steps by 16 from 0 to 4080, then wraps to 0.
- Square, duty=64, ftw=2^24 → 64 samples at 4095, then 192 at 1.
- Triangle, amp=128 → dout peaks at 2048+1023 and troughs at 2048-1024.
- Config change mid-period with en=1 → cfg_ready low until wrap; old wave continues through the wrap sample and the new wave starts on the next sample. cfg_phase_rst=1 gives p=0 on the next sample.
- Assert rst_n=0 during streaming → next cycle dout=2048, dout_valid=0, cfg_ready=1; a pending config is lost.
